// File: rtl/sly_pkg.sv
// Shared Sly-Man-Says definitions: color encoding, LED bit order, reader FSM states.
package sly_pkg;

  typedef logic [1:0] color_t;

  localparam color_t COLOR_RED    = 2'd0;
  localparam color_t COLOR_BLUE   = 2'd1;
  localparam color_t COLOR_GREEN  = 2'd2;
  localparam color_t COLOR_YELLOW = 2'd3;

  // LED vectors are ordered {yellow, green, blue, red}
  localparam int unsigned LED_RED    = 0;
  localparam int unsigned LED_BLUE   = 1;
  localparam int unsigned LED_GREEN  = 2;
  localparam int unsigned LED_YELLOW = 3;

  localparam int unsigned CLOCK_FREQ = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } reader_state_t;

  function automatic logic [3:0] color_onehot(input color_t c);
    logic [3:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic color_t onehot_color(input logic [3:0] v);
    if (v[LED_YELLOW])     return COLOR_YELLOW;
    else if (v[LED_GREEN]) return COLOR_GREEN;
    else if (v[LED_BLUE])  return COLOR_BLUE;
    else                   return COLOR_RED;
  endfunction

endpackage

// File: rtl/button_reader_sync2.sv
// Two-flop synchronizer for one asynchronous input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_reader.sv
// Turns four raw push-buttons into debounced, single press events with a
// one-entry valid/ready register, and echoes the held button on the LEDs.
module button_reader
  import sly_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CLOCK_FREQ / 100,
  parameter int unsigned CNT_W           = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         red_btn,
  input  logic         blue_btn,
  input  logic         green_btn,
  input  logic         yellow_btn,
  output logic         press_valid,
  output color_t       press_color,
  input  logic         press_ready,
  output logic         press_overrun,
  output logic         multi_press,
  output logic [3:0]   btn_leds
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]     raw;
  logic [3:0]     s;
  reader_state_t  state;
  color_t         cand;
  logic [CNT_W-1:0] cnt;
  logic           gen;

  assign raw = {yellow_btn, green_btn, blue_btn, red_btn};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    sync2 u_sync (
      .clk   (clock),
      .rst_n (reset_n),
      .d     (raw[i]),
      .q     (s[i])
    );
  end

  always_comb begin
    gen = (state == ST_DEBOUNCE) && (s == color_onehot(cand)) && (cnt == CNT_MAX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cand          <= COLOR_RED;
      cnt           <= '0;
      btn_leds      <= '0;
      multi_press   <= 1'b0;
      press_valid   <= 1'b0;
      press_color   <= COLOR_RED;
      press_overrun <= 1'b0;
    end else begin
      multi_press   <= 1'b0;
      press_overrun <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if ($countones(s) == 1) begin
            cand  <= onehot_color(s);
            cnt   <= '0;
            state <= ST_DEBOUNCE;
          end else if (s != '0) begin
            multi_press <= 1'b1;
            cnt         <= '0;
            state       <= ST_RELEASE;
          end
        end
        ST_DEBOUNCE: begin
          if (s != color_onehot(cand)) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_MAX) begin
            btn_leds <= color_onehot(cand);
            state    <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (s == '0) begin
            btn_leds <= '0;
            cnt      <= '0;
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (s != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A generate racing an accept replaces the event rather than overrunning.
      if (gen) begin
        if (press_valid && !press_ready) begin
          press_overrun <= 1'b1;
        end else begin
          press_valid <= 1'b1;
          press_color <= cand;
        end
      end else if (press_valid && press_ready) begin
        press_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Randomized and directed bench for button_reader against a run-length model.
module tb_button_reader;

  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       red_btn = 1'b0, blue_btn = 1'b0, green_btn = 1'b0, yellow_btn = 1'b0;
  logic       press_valid;
  logic [1:0] press_color;
  logic       press_ready = 1'b1;
  logic       press_overrun;
  logic       multi_press;
  logic [3:0] btn_leds;

  int n_cmp = 0;
  int n_bad = 0;

  button_reader #(.DEBOUNCE_CYCLES(DC), .CNT_W(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .red_btn       (red_btn),
    .blue_btn      (blue_btn),
    .green_btn     (green_btn),
    .yellow_btn    (yellow_btn),
    .press_valid   (press_valid),
    .press_color   (press_color),
    .press_ready   (press_ready),
    .press_overrun (press_overrun),
    .multi_press   (multi_press),
    .btn_leds      (btn_leds)
  );

  always #5 clock = ~clock;

  // Reference model: samples seen by the reader lag the raw buttons by two edges;
  // a lone button is accepted after DC+1 identical samples, and the reader rearms
  // only after DC consecutive all-released samples following a press or multi-press.
  bit [3:0] sq[$];
  int       qual_len, quiet_zeros;
  bit       holding, quieting;
  bit [1:0] qual_col;
  bit       pend;
  bit [1:0] pcol;
  bit       e_over, e_multi;

  function automatic bit [3:0] raw_vec();
    return {yellow_btn, green_btn, blue_btn, red_btn};
  endfunction

  function automatic bit [8:0] expected();
    bit [3:0] leds;
    leds = holding ? (4'b0001 << qual_col) : 4'b0000;
    return {pend, pcol, e_over, e_multi, leds};
  endfunction

  function automatic bit [8:0] observed();
    return {press_valid, press_color, press_overrun, multi_press, btn_leds};
  endfunction

  task automatic model_reset();
    sq = {4'b0, 4'b0};
    qual_len = 0; quiet_zeros = 0; holding = 0; quieting = 0; qual_col = 0;
    pend = 0; pcol = 0; e_over = 0; e_multi = 0;
  endtask

  task automatic model_edge();
    bit [3:0] s;
    bit       gen;
    s = sq.pop_front();
    sq.push_back(raw_vec());
    gen = 0; e_over = 0; e_multi = 0;
    if (holding) begin
      if (s == 0) begin holding = 0; quieting = 1; quiet_zeros = 0; end
    end else if (quieting) begin
      quiet_zeros = (s == 0) ? quiet_zeros + 1 : 0;
      if (quiet_zeros == DC) quieting = 0;
    end else if (qual_len > 0) begin
      if (s != (4'b0001 << qual_col)) qual_len = 0;
      else begin
        qual_len++;
        if (qual_len == DC + 1) begin gen = 1; qual_len = 0; holding = 1; end
      end
    end else if ($countones(s) == 1) begin
      qual_len = 1;
      for (int i = 0; i < 4; i++) if (s[i]) qual_col = 2'(i);
    end else if (s != 0) begin
      e_multi = 1; quieting = 1; quiet_zeros = 0;
    end
    if (gen) begin
      if (pend && !press_ready) e_over = 1;
      else begin pend = 1; pcol = qual_col; end
    end else if (pend && press_ready) pend = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clock);
  endtask

  task automatic set_btns(input bit [3:0] v);
    {yellow_btn, green_btn, blue_btn, red_btn} = v;
  endtask

  task automatic settle(input int n);
    set_btns(4'b0000);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (observed() !== 9'h000) begin
      n_bad++; $display("FAIL reset_outputs got %h want %h", observed(), 9'h000);
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL reset_idle got %h want %h", observed(), expected());
      end
    end
  endtask

  task automatic test_clean_press();
    press_ready = 1'b1;
    set_btns(4'b0100);
    for (int t = 1; t <= 12; t++) begin
      tick();
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL clean_model t=%0d got %h want %h", t, observed(), expected());
      end
      if (t == 6 || t == 7 || t == 8) begin
        n_cmp++;
        if (press_valid !== (t == 7)) begin
          n_bad++; $display("FAIL clean_latency t=%0d valid got %b want %b", t, press_valid, t == 7);
        end
      end
    end
    n_cmp++;
    if (btn_leds !== 4'b0100 || press_color !== 2'd2) begin
      n_bad++; $display("FAIL clean_held leds=%b color=%0d want 0100 / 2", btn_leds, press_color);
    end
    set_btns(4'b0000);
    for (int t = 0; t < 9; t++) begin
      tick();
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL clean_release got %h want %h", observed(), expected());
      end
    end
    n_cmp++;
    if (btn_leds !== 4'b0000 || press_valid !== 1'b0) begin
      n_bad++; $display("FAIL clean_idle leds=%b valid=%b want 0000 / 0", btn_leds, press_valid);
    end
  endtask

  task automatic test_bounce();
    int events = 0;
    int lat = -1;
    press_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      set_btns((p % 2 == 0) ? 4'b0001 : 4'b0000);
      for (int i = 0; i < 2; i++) begin
        tick();
        if (press_valid) events++;
        n_cmp++;
        if (observed() !== expected()) begin
          n_bad++; $display("FAIL bounce_toggle got %h want %h", observed(), expected());
        end
      end
    end
    set_btns(4'b0001);
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (press_valid) begin events++; if (lat < 0) lat = t; end
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL bounce_held got %h want %h", observed(), expected());
      end
    end
    n_cmp++;
    if (events !== 1 || lat !== DC + 3 || press_color !== 2'd0) begin
      n_bad++;
      $display("FAIL bounce_event count=%0d lat=%0d color=%0d want 1 / %0d / 0", events, lat, press_color, DC + 3);
    end
    settle(10);
  endtask

  task automatic test_multi_press();
    int ev_col = -1;
    press_ready = 1'b1;
    set_btns(4'b1010);
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_cmp++;
      if (multi_press !== (t == 3) || press_valid !== 1'b0) begin
        n_bad++; $display("FAIL multi_pulse t=%0d multi=%b valid=%b want %b / 0", t, multi_press, press_valid, t == 3);
      end
    end
    settle(10);
    set_btns(4'b0010);
    for (int t = 0; t < 10; t++) begin
      tick();
      if (press_valid) ev_col = press_color;
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL multi_model got %h want %h", observed(), expected());
      end
    end
    n_cmp++;
    if (ev_col !== 1) begin
      n_bad++; $display("FAIL multi_lone_blue color got %0d want 1", ev_col);
    end
    settle(10);
  endtask

  task automatic test_backpressure();
    int overruns = 0;
    press_ready = 1'b0;
    set_btns(4'b1000);
    for (int t = 0; t < 10; t++) tick();
    settle(10);
    set_btns(4'b0001);
    for (int t = 0; t < 10; t++) begin
      tick();
      if (press_overrun) overruns++;
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL bp_model got %h want %h", observed(), expected());
      end
    end
    n_cmp++;
    if (overruns !== 1 || press_valid !== 1'b1 || press_color !== 2'd3) begin
      n_bad++;
      $display("FAIL bp_overrun count=%0d valid=%b color=%0d want 1 / 1 / 3", overruns, press_valid, press_color);
    end
    settle(10);
    press_ready = 1'b1;
    tick();
    n_cmp++;
    if (press_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_accept valid got %b want 0", press_valid);
    end
  endtask

  task automatic test_reset_mid_press();
    int lat = -1;
    press_ready = 1'b0;
    set_btns(4'b0010);
    for (int t = 0; t < 10; t++) tick();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== 9'h000) begin
      n_bad++; $display("FAIL midreset_outputs got %h want %h", observed(), 9'h000);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    press_ready = 1'b1;
    for (int t = 1; t <= 20 && lat < 0; t++) begin
      tick();
      if (press_valid) lat = t;
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL midreset_model got %h want %h", observed(), expected());
      end
    end
    n_cmp++;
    if (lat !== DC + 3 || press_color !== 2'd1) begin
      n_bad++; $display("FAIL midreset_event lat=%0d color=%0d want %0d / 1", lat, press_color, DC + 3);
    end
    settle(10);
  endtask

  task automatic test_back_to_back();
    press_ready = 1'b0;
    set_btns(4'b0100);
    for (int t = 0; t < 10; t++) tick();
    settle(10);
    set_btns(4'b0001);
    for (int t = 1; t <= 10; t++) begin
      press_ready = (t == DC + 3);
      tick();
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL b2b_model t=%0d got %h want %h", t, observed(), expected());
      end
      if (t == DC + 3) begin
        n_cmp++;
        if (press_valid !== 1'b1 || press_color !== 2'd0 || press_overrun !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_swap valid=%b color=%0d overrun=%b want 1 / 0 / 0", press_valid, press_color, press_overrun);
        end
      end
    end
    press_ready = 1'b1;
    settle(10);
  endtask

  task automatic test_random();
    bit [3:0] v;
    int       len;
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:       v = 4'b0000;
        3, 4, 5, 6, 7: v = 4'b0001 << $urandom_range(0, 3);
        8:             v = 4'b0011 << $urandom_range(0, 2);
        default:       v = 4'($urandom_range(0, 15));
      endcase
      set_btns(v);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        press_ready = ($urandom_range(0, 3) != 0);
        tick();
        n_cmp++;
        if (observed() !== expected()) begin
          n_bad++; $display("FAIL random seg=%0d got %h want %h", seg, observed(), expected());
        end
      end
    end
    press_ready = 1'b1;
    settle(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_press();
    test_backpressure();
    test_reset_mid_press();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the LED drivers in the Sly-Man-Says game: reads the four player push-buttons (red, blue, green, yellow) and turns them into clean, single press events for the game FSM.
- Pipeline: two-flop synchronizer, then debounce, then single-button arbitration, then a one-entry valid/ready event register.
- Also echoes the held button to the matching LED, so the player sees the press acknowledged.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles an input must be stable to count as pressed or released (10 ms at 50 MHz); legal range is 2 or more; benches override it to 4.
- CNT_W, 32, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- red_btn  in  1  raw button, active-high, asynchronous to clock
- blue_btn  in  1  raw button, active-high
- green_btn  in  1  raw button, active-high
- yellow_btn  in  1  raw button, active-high
- press_valid  out  1  a debounced press event is pending
- press_color  out  2  color of the pending event: 0 red, 1 blue, 2 green, 3 yellow
- press_ready  in  1  consumer accepts the event when press_valid is also high
- press_overrun  out  1  one-cycle pulse: a new event was dropped because the previous one was never consumed
- multi_press  out  1  one-cycle pulse: two or more buttons left idle together; no event is produced
- btn_leds  out  4  one-hot echo of the held button, bit order {yellow, green, blue, red}

Behaviour:
- Reset:
  - all outputs are 0; state is IDLE; counter is 0; synchronizer flops are 0.
  - Reset asserted mid-operation aborts immediately and drops any pending event.
  - A button still held when reset releases is treated as a new press (full debounce, then an event).
- Synchronizer: two flops per button. s[3:0] is the synchronized vector, 2 cycles behind the raw inputs.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
  - IDLE:
    - s==0: stay.
    - s one-hot: latch cand = encode(s), cnt=0, go to DEBOUNCE.
    - s has two or more bits set: pulse multi_press, cnt=0, go to RELEASE.
  - DEBOUNCE:
    - s != onehot(cand): go to IDLE with no event (bounce rejected).
    - else if cnt==DEBOUNCE_CYCLES-1: generate an event with color cand, go to HELD.
    - else cnt++.
  - HELD:
    - btn_leds = onehot(cand). btn_leds is 0 in every other state.
    - s==0: cnt=0, go to RELEASE.
    - Extra buttons pressed while held are ignored.
  - RELEASE:
    - s!=0: cnt=0 and stay.
    - s==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - else cnt++.
- Latency: raw input stable from before clock edge k gives press_valid=1 after edge k+2+DEBOUNCE_CYCLES.
- Event register:
  - On generate: press_valid<=1 and press_color<=cand.
  - Accept: press_valid && press_ready with no generate in the same cycle clears press_valid. press_color holds its last value.
  - Generate while press_valid=1 and press_ready=0: keep the old event, drop the new one, pulse press_overrun.
  - Generate in the same cycle as an accept: press_valid stays 1 and press_color takes the new value; no overrun.
- Counter never wraps: it saturates at DEBOUNCE_CYCLES-1 by construction. Compare is unsigned and CNT_W wide.
- Exactly one event per physical press; nothing is emitted on release.

Decomposition:
- Shared package sly_pkg:
  - color typedef (2 bits) with constants COLOR_RED=0, COLOR_BLUE=1, COLOR_GREEN=2, COLOR_YELLOW=3.
  - the {yellow, green, blue, red} bit order for LED vectors.
  - CLOCK_FREQ=50000000.
- The same encoding is reused by the LED/pattern player.
- One natural sub-module: sync2 (2-flop synchronizer, async active-low reset), instantiated four times. The FSM, counter and event register stay in button_reader.

Test Plan (DEBOUNCE_CYCLES=4, press_ready=1 unless stated):
- Clean green press: green_btn=1 from before edge 0 and held -> press_valid=1, press_color=2 after edge 6 for one cycle; btn_leds=0100 while held; release for 7 or more cycles -> state IDLE, btn_leds=0000, no second event.
- Bounce: red_btn toggles 1,0,1,0 every 2 cycles, then held -> no event during the toggling; exactly one event with press_color=0, DEBOUNCE_CYCLES+3 cycles after the final stable rise.
- Multi-press: blue and yellow rise on the same edge -> multi_press pulses one cycle at edge 2, no press_valid; a later lone blue press after full release -> event color 1.
- Backpressure: press_ready=0; press yellow (event color 3 held); release, then press red -> press_overrun pulses, press_color stays 3; raise press_ready -> press_valid drops the next cycle.
- Reset mid-press: assert reset_n=0 while blue is held in HELD with press_valid=1 -> all outputs 0 immediately; deassert with blue still held -> new event color 1 after DEBOUNCE_CYCLES+3 edges.
- Same-cycle accept and generate: press_ready pulsed exactly on the generating edge of a second press -> press_valid stays 1, press_color shows the new color, no overrun.
